// File: rtl/icache_types.sv
// Shared types and geometry for the direct-mapped instruction cache.
// The line geometry is fixed; only the number of lines varies with S_INDEX.
package icache_types;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

    localparam int ADDR_WIDTH     = 32;
    localparam int S_OFFSET       = 5;
    localparam int LINE_WIDTH     = 256;
    localparam int WORDS_PER_LINE = 8;

    function automatic int tag_width(input int s_index);
        return ADDR_WIDTH - S_OFFSET - s_index;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read port, one synchronous write port.
// Only the valid bits are cleared by reset.
module icache_array
    import icache_types::*;
#(
    parameter int  S_INDEX = 3,
    localparam int TAG_W   = tag_width(S_INDEX)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [S_INDEX-1:0]    rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [S_INDEX-1:0]    wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_WIDTH-1:0] wr_data
);

    localparam int LINES = 1 << S_INDEX;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINE_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; a cleared valid bit already makes
    // stale contents unreachable, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Read-only direct-mapped instruction cache: same-cycle hits, one-line refill on
// a miss through a single pmem read handshake.
module inst_cache
    import icache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_read,
    input  logic [31:0]           inst_addr,
    output logic [31:0]           inst_rdata,
    output logic                  inst_resp,
    output logic                  pmem_read,
    output logic [31:0]           pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int TAG_W = tag_width(S_INDEX);

    icache_state_t state_q, state_d;

    logic [TAG_W+S_INDEX-1:0] miss_line_q;
    logic [2:0]               word_sel;
    logic [S_INDEX-1:0]       index;
    logic [TAG_W-1:0]         tag;
    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    logic [LINE_WIDTH-1:0]    rd_data;
    logic                     hit;
    logic                     start_fill;
    logic                     fill;
    logic                     unused_addr_bits;

    assign word_sel         = inst_addr[S_OFFSET-1:2];
    assign index            = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign tag              = inst_addr[ADDR_WIDTH-1:S_OFFSET+S_INDEX];
    assign unused_addr_bits = ^inst_addr[1:0];

    icache_array #(
        .S_INDEX (S_INDEX)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_index (miss_line_q[S_INDEX-1:0]),
        .wr_tag   (miss_line_q[TAG_W+S_INDEX-1:S_INDEX]),
        .wr_data  (pmem_rdata)
    );

    assign hit        = inst_read && rd_valid && (rd_tag == tag);
    assign inst_rdata = rd_data[{word_sel, 5'b0} +: 32];

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        inst_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        start_fill   = 1'b0;
        fill         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inst_read) begin
                    if (hit) begin
                        inst_resp = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_line_q, 5'b0};
                if (pmem_resp) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the memory side at once and abandons any fill in flight.
        if (reset) begin
            inst_resp    = 1'b0;
            pmem_read    = 1'b0;
            pmem_address = '0;
            start_fill   = 1'b0;
            fill         = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start_fill) begin
            miss_line_q <= {tag, index};
        end
    end

endmodule
